// File: rtl/reg_file_sb.sv
// reg_file_sb: integer register file with busy scoreboard for the pipelined core.
//
// Ports:
//   clk        rising-edge clock for all state
//   rst        asynchronous active-low reset
//   rd_addr    NRP packed read addresses, port p at [p*AW +: AW]
//   rd_data    NRP packed combinational read data (write-back bypassed)
//   rd_busy    NRP combinational busy flags (cleared by same-cycle write-back)
//   iss_en     issue strobe, marks iss_addr busy
//   iss_addr   destination register of the issuing instruction
//   wb_en      write-back strobe
//   wb_addr    write-back destination
//   wb_data    write-back data
//   flush      synchronous clear of every busy bit, contents kept
//   busy_cnt   registered count of busy registers
//   sb_err     sticky protocol-error flag
module reg_file_sb #(
    parameter int XLEN    = 32,
    parameter int AW      = 5,
    parameter int NRP     = 2,
    parameter int ZERO_R0 = 1
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [NRP*AW-1:0]   rd_addr,
    output logic [NRP*XLEN-1:0] rd_data,
    output logic [NRP-1:0]      rd_busy,
    input  logic                iss_en,
    input  logic [AW-1:0]       iss_addr,
    input  logic                wb_en,
    input  logic [AW-1:0]       wb_addr,
    input  logic [XLEN-1:0]     wb_data,
    input  logic                flush,
    output logic [AW:0]         busy_cnt,
    output logic                sb_err
);

    localparam int NREGS = 1 << AW;

    logic [XLEN-1:0]  regs_q [NREGS];
    logic [XLEN-1:0]  regs_d [NREGS];
    logic [NREGS-1:0] busy_q, busy_d;
    logic [AW:0]      busy_cnt_q, busy_cnt_d;
    logic             sb_err_q, sb_err_d;
    logic             wb_to_zero;

    assign wb_to_zero = (ZERO_R0 != 0) && (wb_addr == '0);

    always_comb begin
        regs_d = regs_q;
        if (wb_en && !wb_to_zero) begin
            regs_d[wb_addr] = wb_data;
        end
    end

    // Issue is applied after write-back so a same-cycle issue to the same
    // register leaves it busy: the newer producer owns it.
    always_comb begin
        busy_d = busy_q;
        if (flush) begin
            busy_d = '0;
        end else begin
            if (wb_en) begin
                busy_d[wb_addr] = 1'b0;
            end
            if (iss_en) begin
                busy_d[iss_addr] = 1'b1;
            end
        end
        if (ZERO_R0 != 0) begin
            busy_d[0] = 1'b0;
        end
    end

    always_comb begin
        busy_cnt_d = '0;
        for (int i = 0; i < NREGS; i++) begin
            busy_cnt_d = busy_cnt_d + {{AW{1'b0}}, busy_d[i]};
        end
    end

    // Write-back to r0 is never an error; issue checks still apply under flush.
    always_comb begin
        sb_err_d = sb_err_q;
        if (iss_en && busy_q[iss_addr] && !(wb_en && (wb_addr == iss_addr))) begin
            sb_err_d = 1'b1;
        end
        if (wb_en && !flush && (wb_addr != '0) && !busy_q[wb_addr]) begin
            sb_err_d = 1'b1;
        end
    end

    // Bypass is gated by rst so the outputs show the cleared file while
    // reset is held, even if a write-back strobe is still present.
    always_comb begin
        logic [AW-1:0] ra;
        logic          byp;
        ra      = '0;
        byp     = 1'b0;
        rd_data = '0;
        rd_busy = '0;
        for (int p = 0; p < NRP; p++) begin
            ra  = rd_addr[p*AW +: AW];
            byp = rst && wb_en && (wb_addr == ra);
            if ((ZERO_R0 != 0) && (ra == '0)) begin
                rd_data[p*XLEN +: XLEN] = '0;
                rd_busy[p]              = 1'b0;
            end else if (byp) begin
                rd_data[p*XLEN +: XLEN] = wb_data;
                rd_busy[p]              = 1'b0;
            end else begin
                rd_data[p*XLEN +: XLEN] = regs_q[ra];
                rd_busy[p]              = busy_q[ra];
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < NREGS; i++) begin
                regs_q[i] <= '0;
            end
            busy_q     <= '0;
            busy_cnt_q <= '0;
            sb_err_q   <= 1'b0;
        end else begin
            regs_q     <= regs_d;
            busy_q     <= busy_d;
            busy_cnt_q <= busy_cnt_d;
            sb_err_q   <= sb_err_d;
        end
    end

    assign busy_cnt = busy_cnt_q;
    assign sb_err   = sb_err_q;

endmodule

// File: tb/tb_reg_file_sb.sv
module tb_reg_file_sb;

    localparam int XLEN  = 32;
    localparam int AW    = 5;
    localparam int NRP   = 2;
    localparam int NREGS = 32;

    logic                clk = 1'b0;
    logic                rst = 1'b0;
    logic [NRP*AW-1:0]   rd_addr = '0;
    logic [NRP*XLEN-1:0] rd_data;
    logic [NRP-1:0]      rd_busy;
    logic                iss_en = 1'b0;
    logic [AW-1:0]       iss_addr = '0;
    logic                wb_en = 1'b0;
    logic [AW-1:0]       wb_addr = '0;
    logic [XLEN-1:0]     wb_data = '0;
    logic                flush = 1'b0;
    logic [AW:0]         busy_cnt;
    logic                sb_err;

    int chk_cnt  = 0;
    int pass_cnt = 0;

    // reference model state
    logic [XLEN-1:0] m_reg  [NREGS];
    bit              m_busy [NREGS];
    bit              m_err;

    reg_file_sb #(.XLEN(XLEN), .AW(AW), .NRP(NRP), .ZERO_R0(1)) dut (
        .clk(clk), .rst(rst), .rd_addr(rd_addr), .rd_data(rd_data), .rd_busy(rd_busy),
        .iss_en(iss_en), .iss_addr(iss_addr), .wb_en(wb_en), .wb_addr(wb_addr),
        .wb_data(wb_data), .flush(flush), .busy_cnt(busy_cnt), .sb_err(sb_err)
    );

    always #5 clk = ~clk;

    function automatic void model_reset();
        for (int i = 0; i < NREGS; i++) begin
            m_reg[i]  = '0;
            m_busy[i] = 0;
        end
        m_err = 0;
    endfunction

    function automatic int model_cnt();
        int n = 0;
        for (int i = 0; i < NREGS; i++) n += m_busy[i] ? 1 : 0;
        return n;
    endfunction

    function automatic logic [XLEN-1:0] model_rd(input int a);
        if (a == 0) return '0;
        if (wb_en && int'(wb_addr) == a) return wb_data;
        return m_reg[a];
    endfunction

    function automatic logic model_rbusy(input int a);
        if (a == 0) return 1'b0;
        if (wb_en && int'(wb_addr) == a) return 1'b0;
        return m_busy[a];
    endfunction

    // Apply one clock edge of architectural behaviour to the model.
    function automatic void model_edge();
        int ia = int'(iss_addr);
        int wa = int'(wb_addr);
        if (iss_en && m_busy[ia] && !(wb_en && wa == ia)) m_err = 1;
        if (wb_en && !flush && wa != 0 && !m_busy[wa]) m_err = 1;
        if (wb_en && wa != 0) m_reg[wa] = wb_data;
        if (flush) begin
            for (int i = 0; i < NREGS; i++) m_busy[i] = 0;
        end else begin
            if (wb_en) m_busy[wa] = 0;
            if (iss_en && ia != 0) m_busy[ia] = 1;
        end
    endfunction

    task automatic tick();
        @(posedge clk);
        if (rst) model_edge();
        #1;
    endtask

    task automatic idle();
        iss_en = 0; wb_en = 0; flush = 0;
    endtask

    task automatic test_reset();
        rst = 0;
        model_reset();
        #3;
        chk_cnt++;
        if (rd_data !== '0 || busy_cnt !== '0 || sb_err !== 1'b0)
            $display("FAIL reset_state: rd_data=%h busy_cnt=%0d sb_err=%b, want 0/0/0", rd_data, busy_cnt, sb_err);
        else pass_cnt++;
        @(negedge clk); rst = 1;
        tick();
        wb_en = 1; wb_addr = 0; wb_data = 32'hDEADBEEF; rd_addr = {5'd0, 5'd0};
        #1;
        chk_cnt++;
        if (rd_data[31:0] !== 32'h0)
            $display("FAIL r0_bypass: got %h want 0", rd_data[31:0]);
        else pass_cnt++;
        tick();
        idle();
        #1;
        chk_cnt++;
        if (rd_data[31:0] !== 32'h0 || busy_cnt !== 0 || sb_err !== 1'b0)
            $display("FAIL r0_write: rd=%h cnt=%0d err=%b want 0/0/0", rd_data[31:0], busy_cnt, sb_err);
        else pass_cnt++;
    endtask

    task automatic test_bypass();
        iss_en = 1; iss_addr = 5; rd_addr = {5'd0, 5'd5};
        tick();
        idle();
        #1;
        chk_cnt++;
        if (rd_busy[0] !== 1'b1 || busy_cnt !== 1)
            $display("FAIL issue_busy: rd_busy0=%b cnt=%0d want 1/1", rd_busy[0], busy_cnt);
        else pass_cnt++;
        wb_en = 1; wb_addr = 5; wb_data = 32'h1234;
        #1;
        chk_cnt++;
        if (rd_data[31:0] !== 32'h1234 || rd_busy[0] !== 1'b0)
            $display("FAIL bypass: rd=%h busy=%b want 1234/0", rd_data[31:0], rd_busy[0]);
        else pass_cnt++;
        tick();
        idle();
        #1;
        chk_cnt++;
        if (rd_data[31:0] !== 32'h1234 || busy_cnt !== 0 || sb_err !== 1'b0)
            $display("FAIL storage_read: rd=%h cnt=%0d err=%b want 1234/0/0", rd_data[31:0], busy_cnt, sb_err);
        else pass_cnt++;
    endtask

    task automatic test_scoreboard();
        iss_en = 1; iss_addr = 3;
        tick();
        chk_cnt++;
        if (busy_cnt !== 1) $display("FAIL sb_cnt1: got %0d want 1", busy_cnt);
        else pass_cnt++;
        iss_addr = 7;
        tick();
        idle();
        rd_addr = {5'd7, 5'd3};
        #1;
        chk_cnt++;
        if (busy_cnt !== 2 || rd_busy !== 2'b11)
            $display("FAIL sb_cnt2: cnt=%0d rd_busy=%b want 2/11", busy_cnt, rd_busy);
        else pass_cnt++;
        wb_en = 1; wb_addr = 3; wb_data = 32'hA5A5_0003;
        tick();
        idle();
        #1;
        chk_cnt++;
        if (busy_cnt !== 1 || rd_busy !== 2'b10 || rd_data[31:0] !== 32'hA5A5_0003)
            $display("FAIL sb_wb3: cnt=%0d rd_busy=%b rd0=%h want 1/10/a5a50003", busy_cnt, rd_busy, rd_data[31:0]);
        else pass_cnt++;
        wb_en = 1; wb_addr = 7; wb_data = 32'h7;
        tick();
        idle();
    endtask

    task automatic test_simultaneous();
        iss_en = 1; iss_addr = 9;
        tick();
        wb_en = 1; wb_addr = 9; wb_data = 32'hCAFE_0009;
        tick();
        idle();
        rd_addr = {5'd0, 5'd9};
        #1;
        chk_cnt++;
        if (rd_data[31:0] !== 32'hCAFE_0009 || rd_busy[0] !== 1'b1 || busy_cnt !== 1 || sb_err !== 1'b0)
            $display("FAIL simul: rd=%h busy=%b cnt=%0d err=%b want cafe0009/1/1/0",
                     rd_data[31:0], rd_busy[0], busy_cnt, sb_err);
        else pass_cnt++;
        wb_en = 1; wb_addr = 9; wb_data = 32'h9;
        tick();
        idle();
    endtask

    // Legal-biased random traffic keeps sb_err informative; a later phase allows violations.
    task automatic test_random(input int n, input bit legal);
        logic [AW-1:0] a0, a1;
        int e_cnt;
        for (int c = 0; c < n; c++) begin
            a0 = AW'($urandom_range(0, NREGS-1));
            a1 = AW'($urandom_range(0, NREGS-1));
            rd_addr  = {a1, a0};
            iss_addr = AW'($urandom_range(0, NREGS-1));
            wb_addr  = ($urandom_range(0, 3) == 0) ? a0 : AW'($urandom_range(0, NREGS-1));
            wb_data  = $urandom;
            iss_en   = $urandom_range(0, 1);
            wb_en    = $urandom_range(0, 1);
            flush    = ($urandom_range(0, 31) == 0);
            if (legal) begin
                if (m_busy[iss_addr] && !(wb_en && wb_addr == iss_addr)) iss_en = 0;
                if (!m_busy[wb_addr] && wb_addr != 0) wb_en = 0;
            end
            #1;
            chk_cnt++;
            if (rd_data !== {model_rd(int'(a1)), model_rd(int'(a0))} ||
                rd_busy !== {model_rbusy(int'(a1)), model_rbusy(int'(a0))})
                $display("FAIL rand_read c=%0d: rd=%h busy=%b want %h %b", c, rd_data, rd_busy,
                         {model_rd(int'(a1)), model_rd(int'(a0))},
                         {model_rbusy(int'(a1)), model_rbusy(int'(a0))});
            else pass_cnt++;
            tick();
            e_cnt = model_cnt();
            chk_cnt++;
            if (int'(busy_cnt) != e_cnt || sb_err !== m_err)
                $display("FAIL rand_state c=%0d: cnt=%0d err=%b want %0d %b", c, busy_cnt, sb_err, e_cnt, m_err);
            else pass_cnt++;
        end
        idle();
    endtask

    task automatic test_err_flush();
        logic [XLEN-1:0] keep;
        iss_en = 1; iss_addr = 4;
        tick();
        tick();
        idle();
        rd_addr = {5'd0, 5'd4};
        #1;
        chk_cnt++;
        if (sb_err !== 1'b1) $display("FAIL double_issue: err=%b want 1", sb_err);
        else pass_cnt++;
        keep = m_reg[4];
        flush = 1;
        tick();
        idle();
        #1;
        chk_cnt++;
        if (busy_cnt !== 0 || rd_data[31:0] !== keep || sb_err !== 1'b1 || int'(busy_cnt) != model_cnt())
            $display("FAIL flush: cnt=%0d rd=%h err=%b want 0/%h/1", busy_cnt, rd_data[31:0], keep, sb_err);
        else pass_cnt++;
        tick();
        chk_cnt++;
        if (sb_err !== 1'b1) $display("FAIL err_sticky: err=%b want 1", sb_err);
        else pass_cnt++;
    endtask

    task automatic test_async_reset();
        @(negedge clk);
        rst = 0;
        model_reset();
        #1;
        @(negedge clk); rst = 1;
        wb_en = 1; wb_addr = 12; wb_data = 32'h0000_0C0C;
        tick();
        wb_addr = 11; wb_data = 32'h0000_0B0B; iss_en = 1; iss_addr = 11;
        tick();
        wb_en = 1; wb_addr = 10; wb_data = 32'hAAAA_5555; iss_en = 1; iss_addr = 13;
        rd_addr = {5'd12, 5'd10};
        #2;
        rst = 0;
        model_reset();
        #1;
        chk_cnt++;
        if (rd_data !== '0 || busy_cnt !== 0 || sb_err !== 1'b0)
            $display("FAIL async_rst: rd=%h cnt=%0d err=%b want 0/0/0", rd_data, busy_cnt, sb_err);
        else pass_cnt++;
        @(posedge clk); #1;
        idle();
        @(negedge clk); rst = 1;
        tick();
        rd_addr = {5'd11, 5'd10};
        #1;
        chk_cnt++;
        if (rd_data !== '0 || rd_busy !== 2'b00 || busy_cnt !== 0 || sb_err !== 1'b0)
            $display("FAIL post_rst: rd=%h busy=%b cnt=%0d err=%b want 0", rd_data, rd_busy, busy_cnt, sb_err);
        else pass_cnt++;
    endtask

    initial begin
        test_reset();
        test_bypass();
        test_scoreboard();
        test_simultaneous();
        test_random(300, 1'b1);
        test_err_flush();
        test_random(150, 1'b0);
        test_async_reset();
        $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: run exceeded time limit, want completion");
        $display("%0d/%0d checks passed", pass_cnt, chk_cnt + 1);
        $fatal(1);
    end

endmodule
